// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode/bypass sources and the ID/EX operand stage.
// The master drives decode fields and forwarding sources; the slave returns ALU inputs and hazard status.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int OPW  = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [REGW-1:0] id_rd;
  logic [OPW-1:0]  id_alu_op;
  logic            id_src_a_pc;
  logic            id_src_b_imm;
  logic            id_mem_read;
  logic            id_reg_write;
  logic            flush;
  logic            exmem_reg_write;
  logic [REGW-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [REGW-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_result;
  logic            stall_id;
  logic [XLEN-1:0] A_alu;
  logic [XLEN-1:0] B_alu;
  logic [OPW-1:0]  control_alu;
  logic            ex_valid;
  logic [REGW-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [XLEN-1:0] ex_store_data;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_src_a_pc, id_src_b_imm, id_mem_read, id_reg_write, flush,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    input  stall_id, A_alu, B_alu, control_alu, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_store_data
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_src_a_pc, id_src_b_imm, id_mem_read, id_reg_write, flush,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    output stall_id, A_alu, B_alu, control_alu, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_store_data
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand capture, EX/MEM + MEM/WB bypass,
// and load-use hazard stall with bubble insertion.
module id_ex_fwd_mux #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);
  // Younger producer (EX/MEM) wins; x0 always reads the register file value.
  always_comb begin
    fwd_data = rf_data;
    if (rs != '0) begin
      if (exmem_reg_write && exmem_rd == rs)      fwd_data = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs) fwd_data = memwb_result;
    end
  end
endmodule

module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int OPW  = 5
) (
  input logic CLK,
  input logic RESET_N,
  id_ex_operand_stage_if.slave bus
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [OPW-1:0]  alu_op;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            mem_read;
    logic            reg_write;
  } stage_t;

  stage_t stage_d, stage_q;
  logic   stall;

  logic [NUM_OPS-1:0][REGW-1:0] op_rs;
  logic [NUM_OPS-1:0][XLEN-1:0] op_rf;
  logic [NUM_OPS-1:0][XLEN-1:0] op_fwd;

  // Conservative: an rs2 match stalls even when the consumer ignores rs2.
  assign stall = stage_q.valid && stage_q.mem_read && bus.id_valid &&
                 (stage_q.rd != '0) &&
                 ((stage_q.rd == bus.id_rs1) || (stage_q.rd == bus.id_rs2));

  always_comb begin
    stage_d = '{valid:     bus.id_valid,
                pc:        bus.id_pc,
                rs1_data:  bus.id_rs1_data,
                rs2_data:  bus.id_rs2_data,
                imm:       bus.id_imm,
                rs1:       bus.id_rs1,
                rs2:       bus.id_rs2,
                rd:        bus.id_rd,
                alu_op:    bus.id_alu_op,
                src_a_pc:  bus.id_src_a_pc,
                src_b_imm: bus.id_src_b_imm,
                mem_read:  bus.id_mem_read,
                reg_write: bus.id_reg_write};
    if (bus.flush || stall) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
      stage_d.alu_op    = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) stage_q <= '0;
    else          stage_q <= stage_d;
  end

  assign op_rs[0] = stage_q.rs1;
  assign op_rs[1] = stage_q.rs2;
  assign op_rf[0] = stage_q.rs1_data;
  assign op_rf[1] = stage_q.rs2_data;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    id_ex_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd (
      .rs              (op_rs[g]),
      .rf_data         (op_rf[g]),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_rd        (bus.exmem_rd),
      .exmem_result    (bus.exmem_result),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_rd        (bus.memwb_rd),
      .memwb_result    (bus.memwb_result),
      .fwd_data        (op_fwd[g])
    );
  end

  assign bus.stall_id      = stall;
  assign bus.A_alu         = stage_q.src_a_pc  ? stage_q.pc  : op_fwd[0];
  assign bus.B_alu         = stage_q.src_b_imm ? stage_q.imm : op_fwd[1];
  assign bus.ex_store_data = op_fwd[1];
  assign bus.control_alu   = stage_q.alu_op;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_reg_write  = stage_q.reg_write;
  assign bus.ex_mem_read   = stage_q.mem_read;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage; expected outputs per cycle go into a
// scoreboard queue and a separate monitor compares them against the DUT.
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(32), .REGW(5), .OPW(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .REGW(5), .OPW(5)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  typedef struct {
    bit          rst_n, v, sa, sb, mr, rw, fl, exw, wbw;
    logic [31:0] pc, r1d, r2d, imm, exres, wbres;
    logic [4:0]  rs1, rs2, rd, op, exrd, wbrd;
    bit          cd, e_v, e_st, e_rw, e_mr;
    logic [4:0]  e_ctrl, e_rd;
    logic [31:0] e_a, e_b, e_sd;
  } row_t;

  row_t vecs[$];
  row_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic row_t nr();
    row_t r;
    r = '{default: 0};
    r.rst_n = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver has applied the cycle's inputs.
  initial begin
    row_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ex_valid",     32'(bus.ex_valid),     32'(e.e_v));
        chk("stall_id",     32'(bus.stall_id),     32'(e.e_st));
        chk("control_alu",  32'(bus.control_alu),  32'(e.e_ctrl));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.e_rw));
        chk("ex_mem_read",  32'(bus.ex_mem_read),  32'(e.e_mr));
        if (e.cd) begin
          chk("A_alu",         bus.A_alu,         e.e_a);
          chk("B_alu",         bus.B_alu,         e.e_b);
          chk("ex_store_data", bus.ex_store_data, e.e_sd);
          chk("ex_rd",         32'(bus.ex_rd),    32'(e.e_rd));
        end
      end
    end
  end

  initial begin
    row_t r;
    // C0: held in reset from time 0
    r = nr(); r.rst_n = 0; r.v = 1; r.r1d = 32'hAAAA; r.rs1 = 1; r.op = 5'h1F; r.cd = 1;
    vecs.push_back(r);
    // C1: release, present plain ADD
    r = nr(); r.v = 1; r.pc = 32'h100; r.r1d = 5; r.r2d = 7; r.rs1 = 1; r.rs2 = 2; r.rd = 3;
    r.op = 5'h0A; r.rw = 1; r.cd = 1;
    vecs.push_back(r);
    // C2: ADD visible; present ADDI with negative imm
    r = nr(); r.v = 1; r.r1d = 5; r.r2d = 7; r.rs1 = 1; r.rs2 = 2; r.rd = 3; r.op = 5'h0B;
    r.sb = 1; r.imm = 32'hFFFF_FFFC; r.rw = 1;
    r.cd = 1; r.e_v = 1; r.e_a = 5; r.e_b = 7; r.e_sd = 7; r.e_ctrl = 5'h0A; r.e_rd = 3; r.e_rw = 1;
    vecs.push_back(r);
    // C3: ADDI visible
    r = nr(); r.v = 1; r.pc = 32'h200; r.sa = 1; r.rs1 = 1; r.rs2 = 2; r.r1d = 9; r.op = 5'h03;
    r.cd = 1; r.e_v = 1; r.e_a = 5; r.e_b = 32'hFFFF_FFFC; r.e_sd = 7; r.e_ctrl = 5'h0B;
    r.e_rd = 3; r.e_rw = 1;
    vecs.push_back(r);
    // C4: mid-stream reset clears everything immediately
    r = nr(); r.rst_n = 0; r.v = 1; r.r1d = 32'hABCD; r.rs1 = 2; r.op = 5'h04;
    r.exw = 1; r.exrd = 0; r.exres = 32'hDEAD; r.cd = 1;
    vecs.push_back(r);
    // C5: release; stage still empty
    r = nr(); r.v = 1; r.rs1 = 3; r.r1d = 32'h33; r.rs2 = 5; r.r2d = 32'h55; r.rd = 8;
    r.op = 5'h01; r.rw = 1; r.cd = 1;
    vecs.push_back(r);
    // C6: double forward, EX/MEM wins
    r = nr(); r.v = 1; r.rs1 = 3; r.r1d = 32'h33; r.rs2 = 5; r.r2d = 32'h55; r.rd = 8;
    r.op = 5'h01; r.rw = 1;
    r.exw = 1; r.exrd = 3; r.exres = 32'h11; r.wbw = 1; r.wbrd = 3; r.wbres = 32'h22;
    r.cd = 1; r.e_v = 1; r.e_a = 32'h11; r.e_b = 32'h55; r.e_sd = 32'h55; r.e_ctrl = 5'h01;
    r.e_rd = 8; r.e_rw = 1;
    vecs.push_back(r);
    // C7: EX/MEM not writing -> MEM/WB; present x0 consumer
    r = nr(); r.v = 1; r.rs1 = 0; r.r1d = 32'h1234; r.rs2 = 6; r.r2d = 32'h66; r.rd = 9;
    r.op = 5'h02; r.rw = 1;
    r.exw = 0; r.exrd = 3; r.exres = 32'h11; r.wbw = 1; r.wbrd = 3; r.wbres = 32'h22;
    r.cd = 1; r.e_v = 1; r.e_a = 32'h22; r.e_b = 32'h55; r.e_sd = 32'h55; r.e_ctrl = 5'h01;
    r.e_rd = 8; r.e_rw = 1;
    vecs.push_back(r);
    // C8: x0 never forwarded; present a load to x4
    r = nr(); r.v = 1; r.mr = 1; r.rw = 1; r.rd = 4; r.rs1 = 7; r.r1d = 32'h70; r.rs2 = 0;
    r.r2d = 5; r.sb = 1; r.imm = 8; r.op = 5'h00;
    r.exw = 1; r.exrd = 0; r.exres = 32'hDEAD; r.wbw = 1; r.wbrd = 0; r.wbres = 32'hBEEF;
    r.cd = 1; r.e_v = 1; r.e_a = 32'h1234; r.e_b = 32'h66; r.e_sd = 32'h66; r.e_ctrl = 5'h02;
    r.e_rd = 9; r.e_rw = 1;
    vecs.push_back(r);
    // C9: load in EX, consumer of x4 on rs2 in decode -> stall
    r = nr(); r.v = 1; r.rs1 = 9; r.r1d = 32'h90; r.rs2 = 4; r.r2d = 32'h44; r.rd = 10;
    r.op = 5'h01; r.rw = 1;
    r.cd = 1; r.e_v = 1; r.e_st = 1; r.e_a = 32'h70; r.e_b = 8; r.e_sd = 5; r.e_ctrl = 0;
    r.e_rd = 4; r.e_rw = 1; r.e_mr = 1;
    vecs.push_back(r);
    // C10: bubble, decode held
    r = nr(); r.v = 1; r.rs1 = 9; r.r1d = 32'h90; r.rs2 = 4; r.r2d = 32'h44; r.rd = 10;
    r.op = 5'h01; r.rw = 1;
    vecs.push_back(r);
    // C11: consumer forwards load data from MEM/WB; present load to x6
    r = nr(); r.v = 1; r.mr = 1; r.rw = 1; r.rd = 6; r.rs1 = 1; r.r1d = 32'h10; r.op = 5'h00;
    r.wbw = 1; r.wbrd = 4; r.wbres = 32'h99;
    r.cd = 1; r.e_v = 1; r.e_a = 32'h90; r.e_b = 32'h99; r.e_sd = 32'h99; r.e_ctrl = 5'h01;
    r.e_rd = 10; r.e_rw = 1;
    vecs.push_back(r);
    // C12: stall and flush together
    r = nr(); r.v = 1; r.rs1 = 6; r.r1d = 1; r.rs2 = 2; r.r2d = 2; r.op = 5'h05; r.rw = 1;
    r.rd = 11; r.fl = 1;
    r.cd = 1; r.e_v = 1; r.e_st = 1; r.e_a = 32'h10; r.e_b = 0; r.e_sd = 0; r.e_ctrl = 0;
    r.e_rd = 6; r.e_rw = 1; r.e_mr = 1;
    vecs.push_back(r);
    // C13: bubble from C12; flush alone kills a valid decode
    r = nr(); r.v = 1; r.rs1 = 1; r.r1d = 5; r.rs2 = 2; r.op = 5'h07; r.rw = 1; r.rd = 12; r.fl = 1;
    vecs.push_back(r);
    // C14: flushed slot is a bubble; present an invalid slot with nonzero op
    r = nr(); r.v = 0; r.rs1 = 1; r.r1d = 32'h77; r.op = 5'h0C;
    vecs.push_back(r);
    // C15: invalid slot still carries its op and data, but is harmless
    r = nr();
    r.cd = 1; r.e_ctrl = 5'h0C; r.e_a = 32'h77; r.e_b = 0; r.e_sd = 0; r.e_rd = 0;
    vecs.push_back(r);
    // C16: idle
    r = nr(); r.cd = 1;
    vecs.push_back(r);

    foreach (vecs[i]) begin
      @(negedge clk);
      r = vecs[i];
      rst_n                = r.rst_n;
      bus.id_valid         = r.v;
      bus.id_pc            = r.pc;
      bus.id_rs1_data      = r.r1d;
      bus.id_rs2_data      = r.r2d;
      bus.id_imm           = r.imm;
      bus.id_rs1           = r.rs1;
      bus.id_rs2           = r.rs2;
      bus.id_rd            = r.rd;
      bus.id_alu_op        = r.op;
      bus.id_src_a_pc      = r.sa;
      bus.id_src_b_imm     = r.sb;
      bus.id_mem_read      = r.mr;
      bus.id_reg_write     = r.rw;
      bus.flush            = r.fl;
      bus.exmem_reg_write  = r.exw;
      bus.exmem_rd         = r.exrd;
      bus.exmem_result     = r.exres;
      bus.memwb_reg_write  = r.wbw;
      bus.memwb_rd         = r.wbrd;
      bus.memwb_result     = r.wbres;
      sb_q.push_back(r);
    end
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the RV32I core.
- Captures decoded operands and control each cycle, then drives the ALU operand and control inputs (A_alu, B_alu, control_alu).
- Forwards results from EX/MEM and MEM/WB into the ALU operands.
- Detects load-use hazards: stalls decode for one cycle and inserts a bubble.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register address width.
- OPW, 5, ALU control width; matches control_alu.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REGW  register addresses.
- id_alu_op  in  OPW  ALU operation code.
- id_src_a_pc  in  1  operand A = PC (AUIPC/JAL).
- id_src_b_imm  in  1  operand B = immediate.
- id_mem_read  in  1  instruction is a load.
- id_reg_write  in  1  instruction writes rd.
- flush  in  1  branch/jump redirect; kill the decode slot.
- exmem_reg_write  in  1  EX/MEM stage writes a register.
- exmem_rd  in  REGW  EX/MEM destination register.
- exmem_result  in  XLEN  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB stage writes a register.
- memwb_rd  in  REGW  MEM/WB destination register.
- memwb_result  in  XLEN  MEM/WB result.
- stall_id  out  1  hold PC and IF/ID this cycle.
- A_alu, B_alu  out  XLEN  ALU operands.
- control_alu  out  OPW  ALU op.
- ex_valid, ex_rd, ex_reg_write, ex_mem_read  out  registered control passed downstream.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.

Behaviour:
- Reset (RESET_N=0, asynchronous): all stage registers go to 0.
  - ex_valid=0, control_alu=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0.
  - Outputs A_alu=B_alu=ex_store_data=0 and stall_id=0 while in reset.
  - Reset dominates mid-operation; the first capture happens on the first rising edge after release.
- Hazard detection (combinational, registered stage contents vs. decode):
  - stall_id = ex_valid & ex_mem_read & id_valid & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Matches on rs2 even for I-type instructions; this conservative rule is accepted.
- Capture on each rising edge, in priority order:
  - flush=1 or stall_id=1: load a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0, control_alu=0). Data registers are don't-care.
  - Otherwise: load all id_* fields; ex_valid=id_valid.
  - flush and stall_id together: bubble. Decode is also held, which is harmless because fetch redirects.
- Forwarding (combinational, per operand, using the registered rs1/rs2):
  - If the registered rs==0, use the registered data. x0 is never forwarded.
  - Else if exmem_reg_write & exmem_rd==rs, use exmem_result. This has priority.
  - Else if memwb_reg_write & memwb_rd==rs, use memwb_result.
  - Else use the registered register-file data.
- Operand selection:
  - A_alu = src_a_pc ? registered pc : forwarded rs1.
  - B_alu = src_b_imm ? registered imm : forwarded rs2.
  - ex_store_data = forwarded rs2 always.
- control_alu is the registered id_alu_op.
- Latency: one cycle from decode to ALU inputs. Forwarding adds no latency.
- Load-use costs exactly one bubble; the following cycle forwards from MEM/WB.
- Valid gating: when ex_valid=0, the outputs still follow the muxes, but ex_reg_write=0 and ex_mem_read=0 keep them harmless.
- No wrap-around or overflow handling; operands are passed bit-exact.

Test Plan:
- Reset mid-stream: RESET_N low with id_valid=1 → immediately ex_valid=0, A_alu=B_alu=0, control_alu=0. After release, the first edge captures id fields.
- Plain ADD:
  - Stimulus: rs1_data=5, rs2_data=7, rs1=1, rs2=2, no forwarding matches.
  - Response: next cycle A_alu=5, B_alu=7, control_alu=id_alu_op.
  - With src_b_imm=1 and imm=0xFFFFFFFC: B_alu=0xFFFFFFFC.
- Double forward:
  - Stimulus: registered rs1=3; exmem_rd=3 (result 0x11) and memwb_rd=3 (result 0x22), both writing.
  - Response: A_alu=0x11. Drop exmem_reg_write → A_alu=0x22.
- x0 guard: registered rs1=0, exmem_rd=0 writing 0xDEAD → A_alu equals the registered data, not 0xDEAD.
- Load-use:
  - Stimulus: EX holds a load with rd=4; decode has rs2=4.
  - Response: stall_id=1 for one cycle and a bubble appears (ex_valid=0).
  - Next cycle: with memwb_rd=4 result 0x99, B_alu=0x99.
- Flush during stall: flush=1 with stall_id=1 → bubble captured. With flush=1 alone, a valid decode yields ex_valid=0 next cycle.
